// File: rtl/zigzag_pkg.sv
// rtl/zigzag_pkg.sv - shared zigzag types, default parameters and start token
package zigzag_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETUP   = 2'd1,
    EMIT    = 2'd2
  } zz_state_t;

  localparam int ZZ_D_WIDTH       = 8;
  localparam int ZZ_KEY_WIDTH     = 16;
  localparam int ZZ_MAX_NOF_CHARS = 50;

  localparam logic [7:0] ZZ_START_TOKEN = 8'hFA;

endpackage

// File: rtl/zigzag_index_gen.sv
// rtl/zigzag_index_gen.sv - next buffer index, row and last-flag for zigzag readout
module zigzag_index_gen
  import zigzag_pkg::*;
#(
  parameter int KEY_WIDTH = ZZ_KEY_WIDTH
) (
  input  logic [KEY_WIDTH-1:0] key_q,
  input  logic [KEY_WIDTH-1:0] n,
  input  logic [KEY_WIDTH-1:0] row,
  input  logic [KEY_WIDTH-1:0] idx,
  output logic [KEY_WIDTH-1:0] next_idx,
  output logic [KEY_WIDTH-1:0] next_row,
  output logic                 last
);

  logic [KEY_WIDTH-1:0] nof_rows;
  logic [KEY_WIDTH-1:0] step;
  logic [KEY_WIDTH-1:0] cand;
  logic [KEY_WIDTH-1:0] row_inc;

  always_comb begin
    nof_rows = KEY_WIDTH'(1);
    step     = KEY_WIDTH'(1);
    if (key_q == KEY_WIDTH'(2)) begin
      nof_rows = KEY_WIDTH'(2);
      step     = KEY_WIDTH'(2);
    end else if (key_q == KEY_WIDTH'(3)) begin
      // Middle rail of a 3-rail zigzag holds every odd index; outer rails repeat every 4.
      nof_rows = KEY_WIDTH'(3);
      step     = (row == KEY_WIDTH'(1)) ? KEY_WIDTH'(2) : KEY_WIDTH'(4);
    end
    cand    = idx + step;
    row_inc = row + KEY_WIDTH'(1);
    // Row r starts at index r, so a row past n means every remaining row is empty.
    last    = (cand >= n) && ((row_inc >= nof_rows) || (row_inc >= n));
    if (cand < n) begin
      next_idx = cand;
      next_row = row;
    end else begin
      next_idx = row_inc;
      next_row = row_inc;
    end
  end

endmodule

// File: rtl/zigzag_encryption.sv
// rtl/zigzag_encryption.sv - rail-fence (zigzag) encryptor, buffers plaintext until token
// Optional overflow flag output ovf_o enabled by ZIGZAG_ENCRYPTION_OVF_EN.
module zigzag_encryption
  import zigzag_pkg::*;
#(
  parameter int                  D_WIDTH                = ZZ_D_WIDTH,
  parameter int                  KEY_WIDTH              = ZZ_KEY_WIDTH,
  parameter int                  MAX_NOF_CHARS          = ZZ_MAX_NOF_CHARS,
  parameter logic [D_WIDTH-1:0]  START_ENCRYPTION_TOKEN = D_WIDTH'(ZZ_START_TOKEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
`ifdef ZIGZAG_ENCRYPTION_OVF_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int ADDR_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam logic [KEY_WIDTH-1:0] N_MAX = KEY_WIDTH'(MAX_NOF_CHARS);

  zz_state_t state_q, state_d;

  logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
  logic [KEY_WIDTH-1:0] n_q, key_q, row_q, idx_q;
  logic [KEY_WIDTH-1:0] next_row, next_idx;
  logic                 last;
  logic                 take_char, take_token;

  assign take_char  = (state_q == COLLECT) && valid_i && (data_i != START_ENCRYPTION_TOKEN);
  assign take_token = (state_q == COLLECT) && valid_i && (data_i == START_ENCRYPTION_TOKEN)
                      && (n_q != '0);

  zigzag_index_gen #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_index_gen (
    .key_q    (key_q),
    .n        (n_q),
    .row      (row_q),
    .idx      (idx_q),
    .next_idx (next_idx),
    .next_row (next_row),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (take_token) state_d = SETUP;
      SETUP:   state_d = EMIT;
      EMIT:    if (last) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      key_q <= '0;
      row_q <= '0;
      idx_q <= '0;
      busy  <= 1'b0;
      for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (take_char && (n_q != N_MAX)) begin
            buf_q[n_q[ADDR_W-1:0]] <= data_i;
            n_q <= n_q + KEY_WIDTH'(1);
          end
          if (take_token) begin
            key_q <= key;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          row_q <= '0;
          idx_q <= '0;
        end
        EMIT: begin
          if (last) begin
            busy <= 1'b0;
            n_q  <= '0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
          end else begin
            row_q <= next_row;
            idx_q <= next_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (state_q == EMIT);
  assign data_o  = valid_o ? buf_q[idx_q[ADDR_W-1:0]] : '0;

`ifdef ZIGZAG_ENCRYPTION_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)                                ovf_q <= 1'b0;
    else if (take_char && (n_q == N_MAX))   ovf_q <= 1'b1;
    else if ((state_q == EMIT) && last)     ovf_q <= 1'b0;
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_zigzag_encryption.sv
// tb/tb_zigzag_encryption.sv - scoreboard bench for zigzag_encryption
`timescale 1ns/1ps
module tb_zigzag_encryption;

  typedef logic [7:0] bq_t[$];

  localparam logic [7:0] TOKEN = 8'hFA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic [15:0] key = '0;
  logic        busy;
  logic [7:0]  data_o;
  logic        valid_o;
`ifdef ZIGZAG_ENCRYPTION_OVF_EN
  logic        ovf_o;
`endif

  zigzag_encryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key     (key),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
`ifdef ZIGZAG_ENCRYPTION_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  bq_t  exp_q;
  bq_t  out_q;
  int   run_len  = 0;
  int   last_run = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the rails with a bouncing row pointer, then read rail by rail.
  function automatic void model_push(input bq_t m, input int k);
    int rails = (k == 2 || k == 3) ? k : 1;
    int nch   = (m.size() > 50) ? 50 : m.size();
    int rowof[$];
    int r = 0;
    int dir = 1;
    for (int i = 0; i < nch; i++) begin
      rowof.push_back(r);
      if (rails > 1) begin
        if (r == rails - 1) dir = -1;
        if (r == 0) dir = 1;
        r = r + dir;
      end
    end
    for (int row = 0; row < rails; row++)
      for (int i = 0; i < nch; i++)
        if (rowof[i] == row) exp_q.push_back(m[i]);
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_o) begin
        run_len++;
        out_q.push_back(data_o);
        check("busy_in_emit", busy, 1);
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("data_o", data_o, exp_q.pop_front());
      end else begin
        check("idle_data_o", data_o, 0);
        if (run_len > 0) begin
          check("busy_after_last", busy, 0);
          last_run = run_len;
          run_len  = 0;
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] d);
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic send(input bq_t m, input int k);
    out_q.delete();
    model_push(m, k);
    foreach (m[i]) drive_byte(m[i]);
    key = k[15:0];
    drive_byte(TOKEN);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check({tag, "_timeout"}, done, 1);
    @(negedge clk); #1;
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_str(input string tag, input string s);
    check({tag, "_len"}, out_q.size(), s.len());
    check({tag, "_run"}, last_run, s.len());
    for (int i = 0; i < s.len() && i < out_q.size(); i++) check(tag, out_q[i], s[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bq_t big;
    bit  seen;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    send(str2q("HELLOWORLD"), 3);
    wait_idle("k3");
    check_str("k3_str", "HOLELWRDLO");

    send(str2q("HELLOWORLD"), 2);
    wait_idle("k2");
    check_str("k2_str", "HLOOLELWRD");

    send(str2q("ABC"), 5);
    wait_idle("k5");
    check_str("k5_str", "ABC");

    drive_byte(TOKEN);
    repeat (5) begin
      @(negedge clk);
      check("tok_n0_busy", busy, 0);
      check("tok_n0_valid", valid_o, 0);
    end
    @(posedge clk); #1;

    for (int i = 1; i <= 52; i++) big.push_back(8'(i));
    out_q.delete();
    model_push(big, 1);
    foreach (big[i]) drive_byte(big[i]);
`ifdef ZIGZAG_ENCRYPTION_OVF_EN
    check("ovf_set", ovf_o, 1);
`endif
    key = 16'd1;
    drive_byte(TOKEN);
    wait_idle("sat");
    check("sat_len", out_q.size(), 50);
    check("sat_run", last_run, 50);
    if (out_q.size() == 50) begin
      check("sat_first", out_q[0], 8'h01);
      check("sat_last", out_q[49], 8'h32);
    end
`ifdef ZIGZAG_ENCRYPTION_OVF_EN
    check("ovf_clr", ovf_o, 0);
`endif
    @(posedge clk); #1;

    send(str2q("HELLOWORLD"), 3);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 7) seen = 1'b1;
    end
    check("rst_mid_reach3", seen, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", valid_o, 0);
    @(posedge clk); #1;
    send(str2q("AB"), 2);
    wait_idle("ab");
    check_str("ab_str", "AB");
    @(posedge clk); #1;

    send(str2q("HELLOWORLD"), 3);
    for (int c = 0; c < 100 && busy; c++) begin
      key     = 16'd2;
      data_i  = 8'h58;
      valid_i = 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    data_i  = '0;
    wait_idle("busy_ign");
    check_str("busy_ign_str", "HOLELWRDLO");
    @(posedge clk); #1;
    drive_byte(TOKEN);
    repeat (4) begin
      @(negedge clk);
      check("no_store_busy", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/zigzag_encryption.md
ZIGZAG_ENCRYPTION -- requirements
Module: zigzag_encryption

Interface
REQ-001 SHALL have parameters: D_WIDTH, 8, character width; KEY_WIDTH, 16, key width; MAX_NOF_CHARS, 50, buffer depth; START_ENCRYPTION_TOKEN, 8'hFA, end-of-plaintext and start-encryption marker.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port data_i  input  D_WIDTH  plaintext character or token.
REQ-005 SHALL have port valid_i  input  1  data_i qualifier.
REQ-006 SHALL have port key  input  KEY_WIDTH  number of zigzag rails.
REQ-007 SHALL have port busy  output  1  encryption or emission in progress.
REQ-008 SHALL have port data_o  output  D_WIDTH  ciphertext character.
REQ-009 SHALL have port valid_o  output  1  data_o qualifier.

Function
REQ-010 SHALL use one clock, clk, with synchronous active-high reset rst.
REQ-011 SHALL implement states COLLECT, SETUP and EMIT; the reset state is COLLECT.
REQ-012 SHALL, in COLLECT with valid_i=1 and data_i!=token, store data_i at index n and increment n.
REQ-013 SHALL, when n=MAX_NOF_CHARS, drop further characters and saturate n (no wrap).
REQ-014 SHALL, in COLLECT with valid_i=1 and data_i=token and n>0, latch key into key_q and go to SETUP; busy=1 from the next cycle.
REQ-015 SHALL ignore a token received while n=0: stays in COLLECT, busy stays 0.
REQ-016 SHALL, in SETUP (one cycle), compute row bounds from key_q and n and go to EMIT.
REQ-017 SHALL, in EMIT, drive valid_o=1 for exactly n consecutive cycles, one character per cycle; data_o=0 whenever valid_o=0.
REQ-018 SHALL, for key_q=2, emit indices 0,2,4,... followed by 1,3,5,...
REQ-019 SHALL, for key_q=3 (cycle length 4), emit indices 0,4,8,..., then 1,3,5,7,..., then 2,6,10,...
REQ-020 SHALL, for any other key_q value (including 0, 1 and values above 3), emit indices 0..n-1 in order (pass-through).
REQ-021 SHALL keep all index arithmetic KEY_WIDTH wide; no index SHALL reach or exceed n.
REQ-022 SHALL, on the edge following the last character, clear valid_o, busy, n and the buffer and return to COLLECT.
REQ-023 SHALL ignore valid_i, data_i and key changes while busy=1.
REQ-024 SHALL accept a character on the cycle after busy falls.

Reset
REQ-025 SHALL, with rst=1 at a clk edge, set busy=0, valid_o=0, data_o=0, n=0, key_q=0, clear the buffer and enter COLLECT.
REQ-026 SHALL give rst priority over all other events, including mid-EMIT and a simultaneous token; the partial message SHALL be discarded.

Configuration
REQ-027 SHALL, with ZIGZAG_ENCRYPTION_OVF_EN defined, add output ovf_o (1 bit): set when a character is dropped under REQ-013, cleared by rst or when busy falls.
REQ-028 SHALL, without ZIGZAG_ENCRYPTION_OVF_EN, have no ovf_o port and no overflow logic; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL take the state enum, default parameter values and the token constant from shared package zigzag_pkg, which the decryption block also uses.
REQ-030 SHALL use one sub-module, zigzag_index_gen, which produces the next buffer index, row and last-flag from key_q, n and the current row and index.

Verification
REQ-031 Bench SHALL drive "HELLOWORLD", token, key=3 -> "HOLELWRDLO", valid_o high for 10 consecutive cycles.
REQ-032 Bench SHALL drive "HELLOWORLD", token, key=2 -> "HLOOLELWRD"; busy=1 through the last character, 0 on the following edge.
REQ-033 Bench SHALL drive "ABC", token, key=5 -> "ABC"; then token with n=0 -> no busy, no valid_o.
REQ-034 Bench SHALL drive 52 characters 0x01..0x34, token, key=1 -> 50 outputs 0x01..0x32; ovf_o=1 when the macro is defined.
REQ-035 Bench SHALL assert rst on the 3rd output of "HELLOWORLD"/key=3 -> next cycle busy=0, valid_o=0; then "AB", token, key=2 -> "AB".
REQ-036 Bench SHALL change key 3->2 and drive characters during EMIT -> output unchanged ("HOLELWRDLO"), and the extra characters SHALL not be stored.
